// File: rtl/dct_pkg.sv
// Shared types and constants for the 2-D DCT transpose path.
package dct_pkg;

    localparam int BLK = 8;

    typedef logic [2:0] row_idx_t;
    typedef logic [2:0] col_idx_t;

    localparam row_idx_t LAST_ROW = row_idx_t'(BLK - 1);
    localparam col_idx_t LAST_COL = col_idx_t'(BLK - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_t;

endpackage

// File: rtl/dct_transpose_if.sv
// Row-in / column-out stream bundle for dct_transpose; the slave modport is the transpose side.
interface dct_transpose_if #(parameter int W = 16);

    logic                           in_valid;
    logic [dct_pkg::BLK-1:0][W-1:0] in_data;
    logic                           in_sob;
    logic                           in_eob;
    logic                           in_sof;
    logic                           in_ready;
    logic                           in_err;

    logic                           out_valid;
    logic                           out_ready;
    logic [dct_pkg::BLK-1:0][W-1:0] out_data;
    logic                           out_sob;
    logic                           out_eob;
    logic                           out_sof;

    modport master (
        output in_valid, in_data, in_sob, in_eob, in_sof, out_ready,
        input  in_ready, in_err, out_valid, out_data, out_sob, out_eob, out_sof
    );

    modport slave (
        input  in_valid, in_data, in_sob, in_eob, in_sof, out_ready,
        output in_ready, in_err, out_valid, out_data, out_sob, out_eob, out_sof
    );

endinterface

// File: rtl/dct_tbuf_bank.sv
// One 8x8 coefficient bank: whole-row write port, whole-column combinational read port.
import dct_pkg::*;

module dct_tbuf_bank #(
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  row_idx_t               wr_row,
    input  logic [BLK-1:0][W-1:0]  wr_data,
    input  col_idx_t               rd_col,
    output logic [BLK-1:0][W-1:0]  rd_data
);

    // Storage indexed [row][col]
    logic [BLK-1:0][BLK-1:0][W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[wr_row] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < BLK; r++) begin
            rd_data[r] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose.sv
// Ping-pong 8x8 row-to-column transpose buffer for the 2-D DCT path.
// Optional: define DCT_TRANSPOSE_ERR_CNT_EN to add a saturating err_cnt output.
import dct_pkg::*;

module dct_transpose #(
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DCT_TRANSPOSE_ERR_CNT_EN
    output logic [15:0]       err_cnt,
`endif
    dct_transpose_if.slave    bus
);

    bank_state_t state_q [2];
    bank_state_t state_d [2];
    logic [1:0]  sof_q, sof_d;
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    row_idx_t    wr_row_q, wr_row_d;
    col_idx_t    rd_col_q, rd_col_d;
    logic        err_q, err_d;

    bank_state_t           wr_cur;
    logic [1:0]            we;
    row_idx_t              wr_idx;
    logic [BLK-1:0][W-1:0] col_data [2];
    logic                  out_valid_i;
    logic                  rd_fire;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tbuf_bank #(.W(W)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we      (we[b]),
            .wr_row  (wr_idx),
            .wr_data (bus.in_data),
            .rd_col  (rd_col_q),
            .rd_data (col_data[b])
        );
    end

    assign out_valid_i = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAIN);
    assign rd_fire     = out_valid_i && bus.out_ready;

    // Read and write sides touch disjoint banks: writes only hit EMPTY/FILL, reads only FULL/DRAIN
    always_comb begin
        state_d   = state_q;
        sof_d     = sof_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        err_d     = 1'b0;
        we        = 2'b00;
        wr_idx    = wr_row_q;
        wr_cur    = state_q[wr_bank_q];

        if (rd_fire) begin
            if (rd_col_q == LAST_COL) begin
                state_d[rd_bank_q] = EMPTY;
                rd_col_d           = '0;
                rd_bank_d          = ~rd_bank_q;
            end else begin
                state_d[rd_bank_q] = DRAIN;
                rd_col_d           = rd_col_q + col_idx_t'(1);
            end
        end

        if (bus.in_valid) begin
            if (bus.in_sob) begin
                // A sob that aborts a partial block still starts a fresh one in the freed bank
                if (wr_cur == FILL) begin
                    err_d              = 1'b1;
                    wr_cur             = EMPTY;
                    state_d[wr_bank_q] = EMPTY;
                    wr_row_d           = '0;
                end else if (wr_cur != EMPTY) begin
                    err_d = 1'b1;
                end
                if (wr_cur == EMPTY) begin
                    if (bus.in_eob) begin
                        err_d    = 1'b1;
                        wr_row_d = '0;
                    end else begin
                        we[wr_bank_q]      = 1'b1;
                        wr_idx             = '0;
                        state_d[wr_bank_q] = FILL;
                        sof_d[wr_bank_q]   = bus.in_sof;
                        wr_row_d           = row_idx_t'(1);
                    end
                end
            end else if (wr_cur == FILL) begin
                if (bus.in_eob != (wr_row_q == LAST_ROW)) begin
                    err_d              = 1'b1;
                    state_d[wr_bank_q] = EMPTY;
                    wr_row_d           = '0;
                end else if (bus.in_eob) begin
                    we[wr_bank_q]      = 1'b1;
                    state_d[wr_bank_q] = FULL;
                    wr_bank_d          = ~wr_bank_q;
                    wr_row_d           = '0;
                end else begin
                    we[wr_bank_q] = 1'b1;
                    wr_row_d      = wr_row_q + row_idx_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            sof_q      <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            rd_col_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sof_q      <= sof_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            rd_col_q   <= rd_col_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready  = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILL);
    assign bus.in_err    = err_q;
    assign bus.out_valid = out_valid_i;
    assign bus.out_data  = out_valid_i ? col_data[rd_bank_q] : '0;
    assign bus.out_sob   = out_valid_i && (rd_col_q == '0);
    assign bus.out_eob   = out_valid_i && (rd_col_q == LAST_COL);
    assign bus.out_sof   = out_valid_i && sof_q[rd_bank_q] && (rd_col_q == '0);

`ifdef DCT_TRANSPOSE_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_q && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

    // The bank being drained must never be written underneath the reader
    a_no_write_into_read: assert property (@(posedge clk) disable iff (rst)
        !(we[rd_bank_q] && out_valid_i));

    a_hold_when_stalled: assert property (@(posedge clk) disable iff (rst)
        (out_valid_i && !bus.out_ready) |=> (out_valid_i && $stable(bus.out_data)
                                             && $stable(bus.out_sob) && $stable(bus.out_sof)));

endmodule
